alu_param_core: RTL

//  Parametrised ALU datapath with per-operation programmable interrupt matching.
//  Two op modes (A: AND/NAND/OR/XOR, B: XNOR/AND/NOR/OR) on DATA_W-bit operands; registered result.

---
 rtl/alu_param_core_pkg.sv | 40 ++++
 rtl/alu_param_core_if.sv | 35 +++
 rtl/alu_param_core_irq_ctrl.sv | 65 ++++++
 rtl/alu_param_core.sv | 104 ++++++++++
 4 files changed

// File: rtl/alu_param_core_pkg.sv
// Shared types and reset-time match constants for the parameterised ALU core.
// Operation encodings, interrupt index type and default match table.
package alu_param_core_pkg;

    typedef enum logic [1:0] {
        OP_A_AND  = 2'b00,
        OP_A_NAND = 2'b01,
        OP_A_OR   = 2'b10,
        OP_A_XOR  = 2'b11
    } alu_op_a_e;

    typedef enum logic [1:0] {
        OP_B_XNOR = 2'b00,
        OP_B_AND  = 2'b01,
        OP_B_NOR  = 2'b10,
        OP_B_OR   = 2'b11
    } alu_op_b_e;

    typedef logic [2:0] irq_idx_t;

    localparam int MATCH_ENTRIES = 8;

    // Reset value of each match register, indexed by {mode, op}; callers resize to DATA_W.
    function automatic logic [7:0] default_match(input irq_idx_t idx);
        logic [7:0] val;
        case (idx)
            3'd0:    val = 8'hFF;
            3'd1:    val = 8'h00;
            3'd2:    val = 8'hF8;
            3'd3:    val = 8'h83;
            3'd4:    val = 8'hF1;
            3'd5:    val = 8'hF4;
            3'd6:    val = 8'hF5;
            3'd7:    val = 8'hFF;
            default: val = 8'h00;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/alu_param_core_if.sv
// Operation, configuration and result bundle between the bus front-end and the ALU core.
interface alu_param_core_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic              alu_enable;
    logic              alu_enable_a;
    logic              alu_enable_b;
    logic [1:0]        alu_op_a;
    logic [1:0]        alu_op_b;
    logic [DATA_W-1:0] alu_in_a;
    logic [DATA_W-1:0] alu_in_b;
    logic              alu_irq_clr;
    logic              cfg_we;
    logic [2:0]        cfg_idx;
    logic [DATA_W-1:0] cfg_data;
    logic [DATA_W-1:0] alu_out;
    logic              alu_out_vld;
    logic              alu_irq;
    logic [2:0]        alu_irq_src;
    logic [CNT_W-1:0]  alu_irq_cnt;

    modport master (
        output alu_enable, alu_enable_a, alu_enable_b, alu_op_a, alu_op_b,
               alu_in_a, alu_in_b, alu_irq_clr, cfg_we, cfg_idx, cfg_data,
        input  alu_out, alu_out_vld, alu_irq, alu_irq_src, alu_irq_cnt
    );

    modport slave (
        input  alu_enable, alu_enable_a, alu_enable_b, alu_op_a, alu_op_b,
               alu_in_a, alu_in_b, alu_irq_clr, cfg_we, cfg_idx, cfg_data,
        output alu_out, alu_out_vld, alu_irq, alu_irq_src, alu_irq_cnt
    );

endinterface

// File: rtl/alu_param_core_irq_ctrl.sv
// Sticky interrupt flag with first-source capture and a saturating event counter.
// Clear takes priority over a simultaneous match but never touches the counter.
module alu_param_core_irq_ctrl
    import alu_param_core_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             hit,
    input  irq_idx_t         hit_idx,
    output logic             irq,
    output irq_idx_t         irq_src,
    output logic [CNT_W-1:0] irq_cnt
);

    logic             irq_d, irq_q;
    irq_idx_t         src_d, src_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    // Next-state for flag, source and counter.
    always_comb begin
        irq_d = irq_q;
        src_d = src_q;
        cnt_d = cnt_q;
        if (clr) begin
            irq_d = 1'b0;
            src_d = 3'd0;
        end else if (hit) begin
            irq_d = 1'b1;
            // Only the rising edge of the flag records who caused it.
            if (!irq_q) begin
                src_d = hit_idx;
            end else begin
                src_d = src_q;
            end
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            irq_d = irq_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q <= 1'b0;
            src_q <= 3'd0;
            cnt_q <= '0;
        end else begin
            irq_q <= irq_d;
            src_q <= src_d;
            cnt_q <= cnt_d;
        end
    end

    assign irq     = irq_q;
    assign irq_src = src_q;
    assign irq_cnt = cnt_q;

endmodule

// File: rtl/alu_param_core.sv
// Two-mode bitwise ALU with registered result and per-operation match registers
// feeding the interrupt controller.
module alu_param_core
    import alu_param_core_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input logic             alu_clk,
    input logic             alu_rst,
    alu_param_core_if.slave bus
);

    logic              legal_s;
    irq_idx_t          idx_s;
    logic [DATA_W-1:0] result_s;
    logic              hit_s;
    logic [DATA_W-1:0] out_d, out_q;
    logic              vld_d, vld_q;
    logic [DATA_W-1:0] match_d [MATCH_ENTRIES];
    logic [DATA_W-1:0] match_q [MATCH_ENTRIES];

    assign legal_s = bus.alu_enable & (bus.alu_enable_a ^ bus.alu_enable_b);
    assign idx_s   = bus.alu_enable_b ? {1'b1, bus.alu_op_b} : {1'b0, bus.alu_op_a};

    // Operation mux for whichever mode is selected.
    always_comb begin
        result_s = '0;
        if (bus.alu_enable_b) begin
            case (alu_op_b_e'(bus.alu_op_b))
                OP_B_XNOR: result_s = ~(bus.alu_in_a ^ bus.alu_in_b);
                OP_B_AND:  result_s = bus.alu_in_a & bus.alu_in_b;
                OP_B_NOR:  result_s = ~(bus.alu_in_a | bus.alu_in_b);
                OP_B_OR:   result_s = bus.alu_in_a | bus.alu_in_b;
                default:   result_s = '0;
            endcase
        end else begin
            case (alu_op_a_e'(bus.alu_op_a))
                OP_A_AND:  result_s = bus.alu_in_a & bus.alu_in_b;
                OP_A_NAND: result_s = ~(bus.alu_in_a & bus.alu_in_b);
                OP_A_OR:   result_s = bus.alu_in_a | bus.alu_in_b;
                OP_A_XOR:  result_s = bus.alu_in_a ^ bus.alu_in_b;
                default:   result_s = '0;
            endcase
        end
    end

    // Compare against the pre-write match value, so a same-cycle cfg write is not seen.
    assign hit_s = legal_s & (result_s == match_q[idx_s]);

    // Output register next-state: clear beats a legal op, illegal ops hold.
    always_comb begin
        out_d = out_q;
        vld_d = 1'b0;
        if (bus.alu_irq_clr) begin
            out_d = '0;
        end else if (legal_s) begin
            out_d = result_s;
            vld_d = 1'b1;
        end else begin
            out_d = out_q;
        end
    end

    // Match register file write port.
    always_comb begin
        match_d = match_q;
        if (bus.cfg_we) begin
            match_d[bus.cfg_idx] = bus.cfg_data;
        end else begin
            match_d = match_q;
        end
    end

    // Result and match registers.
    always_ff @(posedge alu_clk) begin
        if (alu_rst) begin
            out_q <= '0;
            vld_q <= 1'b0;
            for (int i = 0; i < MATCH_ENTRIES; i++) begin
                match_q[i] <= DATA_W'(default_match(irq_idx_t'(i)));
            end
        end else begin
            out_q   <= out_d;
            vld_q   <= vld_d;
            match_q <= match_d;
        end
    end

    alu_param_core_irq_ctrl #(.CNT_W(CNT_W)) u_irq_ctrl (
        .clk     (alu_clk),
        .rst     (alu_rst),
        .clr     (bus.alu_irq_clr),
        .hit     (hit_s),
        .hit_idx (idx_s),
        .irq     (bus.alu_irq),
        .irq_src (bus.alu_irq_src),
        .irq_cnt (bus.alu_irq_cnt)
    );

    assign bus.alu_out     = out_q;
    assign bus.alu_out_vld = vld_q;

endmodule
